// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: load/store kind, bus access size
// and the stage FSM states, plus small decode helpers.
package mem_access_stage_pkg;

    typedef enum logic [2:0] {
        LS_NONE    = 3'd0,
        LS_BTYE    = 3'd1,
        LS_BTYE_U  = 3'd2,
        LS_HALFW   = 3'd3,
        LS_HALFW_U = 3'd4,
        LS_WORD    = 3'd5
    } ls_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    function automatic msize_t ls_size(ls_t ls);
        msize_t sz;
        case (ls)
            LS_HALFW, LS_HALFW_U: sz = MSIZE2;
            LS_WORD:              sz = MSIZE4;
            default:              sz = MSIZE1;
        endcase
        return sz;
    endfunction

    function automatic logic ls_misaligned(ls_t ls, logic [1:0] off);
        logic mis;
        case (ls)
            LS_HALFW, LS_HALFW_U: mis = off[0];
            LS_WORD:              mis = (off != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data bus between the memory-access stage (master) and the memory side (slave).
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [3:0]        dreq_strobe;
    logic [ADDR_W-1:0] dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [ADDR_W-1:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/mem_lane_ext.sv
// Combinational load extractor: picks the byte/halfword lane out of a raw bus
// word and sign- or zero-extends it. Also usable by the write-back bypass.
module mem_lane_ext
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  off,
    input  ls_t         ls,
    output logic [31:0] ext
);
    logic [7:0]  b_lane;
    logic [15:0] h_lane;

    always_comb begin
        b_lane = 8'(raw >> {off, 3'b000});
        h_lane = 16'(raw >> {off[1], 4'b0000});
        case (ls)
            LS_BTYE:    ext = {{24{b_lane[7]}}, b_lane};
            LS_BTYE_U:  ext = {24'b0, b_lane};
            LS_HALFW:   ext = {{16{h_lane[15]}}, h_lane};
            LS_HALFW_U: ext = {16'b0, h_lane};
            default:    ext = raw;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// Single-entry memory-access stage: issues one data-bus request per load/store,
// aligns/extends load data and holds the result until downstream takes it.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              in_valid,
    output logic              in_ready,
    input  ls_t               in_ls_flag,
    input  logic              in_mem_write_en,
    input  logic              in_reg_write_en,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [ADDR_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_rd,

    mem_access_stage_if.master dbus,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_write_en,
    output logic              out_addr_err
);
    // state | meaning
    // IDLE  | empty, accepting a new entry
    // REQ   | bus request driven, waiting for addr_ok
    // WAIT  | request accepted, waiting for data_ok
    // DONE  | result presented, waiting for out_ready
    mem_state_t        state_q, state_d;
    ls_t               ls_q, ls_d;
    msize_t            size_q, size_d;
    logic              store_q, store_d;
    logic              rwe_q, rwe_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] sdata_q, sdata_d;
    logic [3:0]        strobe_q, strobe_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [ADDR_W-1:0] data_q, data_d;

    logic [31:0] load_ext;
    logic        mis;

    mem_lane_ext u_lane_ext (
        .raw (dbus.dresp_data),
        .off (addr_q[1:0]),
        .ls  (ls_q),
        .ext (load_ext)
    );

    always_comb begin
        state_d  = state_q;
        ls_d     = ls_q;
        size_d   = size_q;
        store_d  = store_q;
        rwe_d    = rwe_q;
        err_d    = err_q;
        addr_d   = addr_q;
        sdata_d  = sdata_q;
        strobe_d = strobe_q;
        rd_d     = rd_q;
        data_d   = data_q;
        mis      = ls_misaligned(in_ls_flag, in_addr[1:0]);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ls_d     = in_ls_flag;
                    size_d   = ls_size(in_ls_flag);
                    store_d  = in_mem_write_en && (in_ls_flag != LS_NONE);
                    rwe_d    = in_reg_write_en && !mis;
                    err_d    = mis;
                    addr_d   = in_addr;
                    rd_d     = in_rd;
                    data_d   = (in_ls_flag == LS_NONE) ? in_addr : '0;
                    strobe_d = 4'b0000;
                    sdata_d  = '0;
                    // Store data is replicated on every lane so the memory only needs the strobe.
                    if (store_d && !mis) begin
                        case (size_d)
                            MSIZE1: begin
                                strobe_d = 4'b0001 << in_addr[1:0];
                                sdata_d  = {4{in_wdata[7:0]}};
                            end
                            MSIZE2: begin
                                strobe_d = 4'b0011 << {in_addr[1], 1'b0};
                                sdata_d  = {2{in_wdata[15:0]}};
                            end
                            default: begin
                                strobe_d = 4'b1111;
                                sdata_d  = in_wdata;
                            end
                        endcase
                    end
                    state_d = ((in_ls_flag == LS_NONE) || mis) ? DONE : REQ;
                end
            end
            REQ: begin
                if (dbus.dresp_addr_ok) begin
                    if (dbus.dresp_data_ok) begin
                        data_d  = store_q ? '0 : load_ext;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dbus.dresp_data_ok) begin
                    data_d  = store_q ? '0 : load_ext;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            ls_q     <= LS_NONE;
            size_q   <= MSIZE1;
            store_q  <= 1'b0;
            rwe_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            sdata_q  <= '0;
            strobe_q <= 4'b0000;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ls_q     <= ls_d;
            size_q   <= size_d;
            store_q  <= store_d;
            rwe_q    <= rwe_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            sdata_q  <= sdata_d;
            strobe_q <= strobe_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
        end
    end

    assign in_ready         = (state_q == IDLE);
    assign dbus.dreq_valid  = (state_q == REQ);
    assign dbus.dreq_addr   = addr_q;
    assign dbus.dreq_size   = size_q;
    assign dbus.dreq_strobe = strobe_q;
    assign dbus.dreq_data   = sdata_q;
    assign out_valid        = (state_q == DONE);
    assign out_data         = data_q;
    assign out_rd           = rd_q;
    assign out_reg_write_en = rwe_q;
    assign out_addr_err     = err_q;

endmodule
